// File: rtl/sim_run_ctrl.sv
// Simulation run controller: sequences the CPU reset, counts RUN cycles and
// committed instructions, and stops the run on halt, deadlock or timeout.
// It latches a final status that the bench reads at the end of the run.
//
// Ports:
//   clk          - single clock; all state updates on the rising edge
//   rst          - synchronous active-high reset
//   start        - begins a run when sampled in IDLE or DONE
//   commit_i     - the CPU retired one instruction this cycle
//   pc_i         - PC of the retiring instruction (valid while commit_i is high)
//   halt_i       - the CPU reports halt
//   cpu_rst_o    - active-high reset to the CPU top (low only in RUN)
//   running_o    - high in RUN
//   done_o       - high in DONE
//   halted_o / deadlock_o / timeout_o - end cause, one-hot in DONE
//   cycle_cnt_o  - RUN cycles elapsed (saturating)
//   instr_cnt_o  - commits counted (saturating)
//   final_pc_o   - PC of the last commit
module sim_run_ctrl #(
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned STALL_LIMIT    = 64,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned PC_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             commit_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             halt_i,
  output logic             cpu_rst_o,
  output logic             running_o,
  output logic             done_o,
  output logic             halted_o,
  output logic             deadlock_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [PC_W-1:0]  final_pc_o
);

  typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

  localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RstW-1:0]  RstLast     = RstW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] StallLast   = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax      = '1;

  state_e            state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              deadlock_q, deadlock_d;
  logic              timeout_q, timeout_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    cycle_d    = cycle_q;
    instr_d    = instr_q;
    stall_d    = stall_q;
    pc_d       = pc_q;
    halted_d   = halted_q;
    deadlock_d = deadlock_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          // A new run starts from a clean status.
          state_d    = StReset;
          rst_cnt_d  = '0;
          cycle_d    = '0;
          instr_d    = '0;
          stall_d    = '0;
          pc_d       = '0;
          halted_d   = 1'b0;
          deadlock_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      StReset: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun: begin
        cycle_d = sat_inc(cycle_q);
        if (commit_i) begin
          instr_d = sat_inc(instr_q);
          pc_d    = pc_i;
          stall_d = '0;
        end else begin
          stall_d = sat_inc(stall_q);
        end
        // stall_q holds the no-commit cycles before this one, so this is the
        // STALL_LIMIT-th consecutive idle cycle.
        if (halt_i) begin
          state_d  = StDone;
          halted_d = 1'b1;
        end else if (!commit_i && (stall_q == StallLast)) begin
          state_d    = StDone;
          deadlock_d = 1'b1;
        end else if (cycle_q == TimeoutLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rst_cnt_q  <= '0;
      cycle_q    <= '0;
      instr_q    <= '0;
      stall_q    <= '0;
      pc_q       <= '0;
      halted_q   <= 1'b0;
      deadlock_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      stall_q    <= stall_d;
      pc_q       <= pc_d;
      halted_q   <= halted_d;
      deadlock_q <= deadlock_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs decode only registered state; no input reaches them combinationally.
  assign cpu_rst_o   = (state_q != StRun);
  assign running_o   = (state_q == StRun);
  assign done_o      = (state_q == StDone);
  assign halted_o    = halted_q;
  assign deadlock_o  = deadlock_q;
  assign timeout_o   = timeout_q;
  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;
  assign final_pc_o  = pc_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl. Two instances share the stimulus: dut_a has
// a long timeout (halt/deadlock/reset runs), dut_b a 20-cycle timeout.
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, commit, halt;
  logic [31:0] pc;

  logic        a_cpu_rst, a_running, a_done, a_halted, a_deadlock, a_timeout;
  logic [31:0] a_cycle, a_instr, a_pc;
  logic        b_cpu_rst, b_running, b_done, b_halted, b_deadlock, b_timeout;
  logic [31:0] b_cycle, b_instr, b_pc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        halted;
    logic        deadlock;
    logic        timeout;
    logic [31:0] cyc;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  sim_run_ctrl #(
    .RESET_CYCLES  (4),
    .TIMEOUT_CYCLES(1000),
    .STALL_LIMIT   (8),
    .CNT_W         (32),
    .PC_W          (32)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .commit_i   (commit),
    .pc_i       (pc),
    .halt_i     (halt),
    .cpu_rst_o  (a_cpu_rst),
    .running_o  (a_running),
    .done_o     (a_done),
    .halted_o   (a_halted),
    .deadlock_o (a_deadlock),
    .timeout_o  (a_timeout),
    .cycle_cnt_o(a_cycle),
    .instr_cnt_o(a_instr),
    .final_pc_o (a_pc)
  );

  sim_run_ctrl #(
    .RESET_CYCLES  (4),
    .TIMEOUT_CYCLES(20),
    .STALL_LIMIT   (8),
    .CNT_W         (32),
    .PC_W          (32)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .commit_i   (commit),
    .pc_i       (pc),
    .halt_i     (halt),
    .cpu_rst_o  (b_cpu_rst),
    .running_o  (b_running),
    .done_o     (b_done),
    .halted_o   (b_halted),
    .deadlock_o (b_deadlock),
    .timeout_o  (b_timeout),
    .cycle_cnt_o(b_cycle),
    .instr_cnt_o(b_instr),
    .final_pc_o (b_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit use_b, input int budget);
    int n = 0;
    while (((use_b ? b_done : a_done) !== 1'b1) && (n < budget)) begin
      step();
      n++;
    end
    chk(use_b ? "b_done_seen" : "a_done_seen", use_b ? b_done : a_done, 1);
  endtask

  task automatic check_pop(input bit use_b, input string tag);
    exp_t e;
    chk({tag, "_sb_entry"}, (sb_q.size() > 0) ? 32'd1 : 32'd0, 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk({tag, "_halted"},   use_b ? b_halted   : a_halted,   e.halted);
    chk({tag, "_deadlock"}, use_b ? b_deadlock : a_deadlock, e.deadlock);
    chk({tag, "_timeout"},  use_b ? b_timeout  : a_timeout,  e.timeout);
    chk({tag, "_cycles"},   use_b ? b_cycle    : a_cycle,    e.cyc);
    chk({tag, "_instrs"},   use_b ? b_instr    : a_instr,    e.instr);
    chk({tag, "_pc"},       use_b ? b_pc       : a_pc,       e.pc);
    chk({tag, "_cpu_rst"},  use_b ? b_cpu_rst  : a_cpu_rst,  1);
  endtask

  // Start pulse, then the four RESET cycles; ends on the first RUN cycle.
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; commit = 1'b0; halt = 1'b0; pc = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_cpu_rst", a_cpu_rst, 1);
    chk("rst_running", a_running, 0);
    chk("rst_done", a_done, 0);
    chk("rst_flags", {a_halted, a_deadlock, a_timeout}, 0);
    chk("rst_cycle", a_cycle, 0);
    chk("rst_instr", a_instr, 0);
    chk("rst_pc", a_pc, 0);

    // Start timing: cpu_rst held through RESET, drops on the first RUN cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("reset_cpu_rst_0", a_cpu_rst, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("reset_cpu_rst", a_cpu_rst, 1);
      chk("reset_running", a_running, 0);
    end
    step();
    chk("run_cpu_rst", a_cpu_rst, 0);
    chk("run_running", a_running, 1);

    // Normal halt: commit every third cycle, halt with the 10th commit.
    sb_q.push_back('{halted: 1'b1, deadlock: 1'b0, timeout: 1'b0,
                     cyc: 32'd30, instr: 32'd10, pc: 32'h24});
    for (int k = 1; k <= 30; k++) begin
      commit = (k % 3 == 0);
      pc     = (k % 3 == 0) ? 32'((k / 3 - 1) * 4) : 32'hffff_ffff;
      halt   = (k == 30);
      step();
    end
    commit = 1'b0; halt = 1'b0;
    wait_done(1'b0, 5);
    check_pop(1'b0, "halt");
    // DONE ignores further commits.
    commit = 1'b1; pc = 32'hdead;
    step();
    step();
    commit = 1'b0;
    chk("done_hold_instr", a_instr, 10);
    chk("done_hold_pc", a_pc, 32'h24);
    chk("done_hold_done", a_done, 1);

    // Restart from DONE: status cleared on RESET entry, then a deadlock run.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_cycle", a_cycle, 0);
    chk("restart_instr", a_instr, 0);
    chk("restart_pc", a_pc, 0);
    chk("restart_flags", {a_halted, a_deadlock, a_timeout, a_done}, 0);
    repeat (4) step();
    chk("restart_running", a_running, 1);
    for (int k = 1; k <= 3; k++) begin
      commit = 1'b1;
      pc     = 32'h100 + 32'((k - 1) * 4);
      step();
    end
    commit = 1'b0;
    repeat (7) step();
    chk("deadlock_not_early", a_done, 0);
    sb_q.push_back('{halted: 1'b0, deadlock: 1'b1, timeout: 1'b0,
                     cyc: 32'd11, instr: 32'd3, pc: 32'h108});
    wait_done(1'b0, 5);
    check_pop(1'b0, "deadlock");

    // Timeout on dut_b: commit every cycle, no halt.
    launch();
    chk("to_running", b_running, 1);
    sb_q.push_back('{halted: 1'b0, deadlock: 1'b0, timeout: 1'b1,
                     cyc: 32'd20, instr: 32'd20, pc: 32'h4c});
    for (int k = 1; k <= 20; k++) begin
      commit = 1'b1;
      pc     = 32'((k - 1) * 4);
      step();
    end
    commit = 1'b0;
    wait_done(1'b1, 3);
    check_pop(1'b1, "timeout");

    // start in RUN is ignored (dut_a is still running here).
    launch();
    chk("start_ignored_in_run", a_running, 1);

    // Halt on the timeout cycle: halt wins.
    sb_q.push_back('{halted: 1'b1, deadlock: 1'b0, timeout: 1'b0,
                     cyc: 32'd20, instr: 32'd20, pc: 32'h4c});
    for (int k = 1; k <= 20; k++) begin
      commit = 1'b1;
      pc     = 32'((k - 1) * 4);
      halt   = (k == 20);
      step();
    end
    commit = 1'b0; halt = 1'b0;
    wait_done(1'b1, 3);
    check_pop(1'b1, "halt_vs_timeout");

    // rst mid-RUN returns to IDLE with reset outputs.
    rst = 1'b1;
    step();
    rst = 1'b0;
    launch();
    chk("rerun_running", a_running, 1);
    commit = 1'b1; pc = 32'h40;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0; commit = 1'b0;
    chk("midrst_cpu_rst", a_cpu_rst, 1);
    chk("midrst_running", a_running, 0);
    chk("midrst_done", a_done, 0);
    chk("midrst_flags", {a_halted, a_deadlock, a_timeout}, 0);
    chk("midrst_cycle", a_cycle, 0);
    chk("midrst_instr", a_instr, 0);
    chk("midrst_pc", a_pc, 0);

    // rst overrides start.
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    repeat (6) step();
    chk("rst_over_start_running", a_running, 0);
    chk("rst_over_start_cpu_rst", a_cpu_rst, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
